mem_bus_ctrl: RTL



---
 rtl/mem_bus_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: arbitrates one single-port RAM between instruction fetch and
// the MEM stage. Each access is a registered req/ack transaction. Each
// requester is stalled until its own transaction completes. A watchdog aborts
// accesses that the RAM never acknowledges.
module mem_bus_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_ce_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_stallreq_o,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        mem_stallreq_o,
    input  logic        flush_i,
    output logic        ram_ce_o,
    output logic        ram_we_o,
    output logic [3:0]  ram_sel_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_data_o,
    input  logic [31:0] ram_data_i,
    input  logic        ram_ack_i,
    output logic        bus_err_o
);

    // The counter keeps at least one bit so that TIMEOUT=0 (watchdog off) still elaborates.
    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam bit WDOG_ON = (TIMEOUT != 0);

    typedef enum logic [1:0] {IDLE, D_WAIT, I_WAIT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          d_done_q, d_done_d;
    logic          i_done_q, i_done_d;
    logic          iflush_q, iflush_d;     // fetch in flight was flushed; discard its result
    logic          ram_ce_q, ram_ce_d;
    logic          ram_we_q, ram_we_d;
    logic [3:0]    ram_sel_q, ram_sel_d;
    logic [31:0]   ram_addr_q, ram_addr_d;
    logic [31:0]   ram_data_q, ram_data_d;
    logic [31:0]   if_data_q, if_data_d;
    logic [31:0]   mem_data_q, mem_data_d;
    logic          bus_err_q, bus_err_d;

    logic d_req, i_req, expired, finish;
    logic [31:0] rd_word;

    assign d_req   = mem_ce_i & ~d_done_q;
    assign i_req   = if_ce_i & ~i_done_q & ~flush_i;
    assign expired = WDOG_ON && (cnt_q == CNT_LAST) && !ram_ack_i;
    assign finish  = ram_ack_i | expired;
    // A watchdog abort returns zero instead of whatever is on the RAM data bus.
    assign rd_word = ram_ack_i ? ram_data_i : 32'h0;

    // Next-state, arbitration and registered-output computation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        d_done_d   = 1'b0;
        i_done_d   = 1'b0;
        iflush_d   = iflush_q;
        ram_ce_d   = ram_ce_q;
        ram_we_d   = ram_we_q;
        ram_sel_d  = ram_sel_q;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        if_data_d  = if_data_q;
        mem_data_d = mem_data_q;
        bus_err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // Data side first: it belongs to the older instruction.
                if (d_req) begin
                    state_d    = D_WAIT;
                    cnt_d      = '0;
                    ram_ce_d   = 1'b1;
                    ram_we_d   = mem_we_i;
                    ram_sel_d  = mem_sel_i;
                    ram_addr_d = mem_addr_i;
                    ram_data_d = mem_data_i;
                end else if (i_req) begin
                    state_d    = I_WAIT;
                    cnt_d      = '0;
                    iflush_d   = 1'b0;
                    ram_ce_d   = 1'b1;
                    ram_we_d   = 1'b0;
                    ram_sel_d  = 4'hF;
                    ram_addr_d = if_addr_i;
                    ram_data_d = 32'h0;
                end
            end
            D_WAIT: begin
                if (finish) begin
                    state_d   = IDLE;
                    ram_ce_d  = 1'b0;
                    ram_we_d  = 1'b0;
                    d_done_d  = 1'b1;
                    bus_err_d = expired;
                    if (!ram_we_q) begin
                        mem_data_d = rd_word;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            I_WAIT: begin
                if (flush_i) begin
                    iflush_d = 1'b1;
                end
                if (finish) begin
                    state_d   = IDLE;
                    ram_ce_d  = 1'b0;
                    ram_we_d  = 1'b0;
                    bus_err_d = expired;
                    if (!flush_i && !iflush_q) begin
                        i_done_d  = 1'b1;
                        if_data_d = rd_word;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                ram_ce_d = 1'b0;
                ram_we_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            d_done_q   <= 1'b0;
            i_done_q   <= 1'b0;
            iflush_q   <= 1'b0;
            ram_ce_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_sel_q  <= 4'h0;
            ram_addr_q <= 32'h0;
            ram_data_q <= 32'h0;
            if_data_q  <= 32'h0;
            mem_data_q <= 32'h0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            d_done_q   <= d_done_d;
            i_done_q   <= i_done_d;
            iflush_q   <= iflush_d;
            ram_ce_q   <= ram_ce_d;
            ram_we_q   <= ram_we_d;
            ram_sel_q  <= ram_sel_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            if_data_q  <= if_data_d;
            mem_data_q <= mem_data_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign if_stallreq_o  = if_ce_i & ~i_done_q & ~flush_i;
    assign mem_stallreq_o = mem_ce_i & ~d_done_q;
    assign if_data_o      = if_data_q;
    assign mem_data_o     = mem_data_q;
    assign ram_ce_o       = ram_ce_q;
    assign ram_we_o       = ram_we_q;
    assign ram_sel_o      = ram_sel_q;
    assign ram_addr_o     = ram_addr_q;
    assign ram_data_o     = ram_data_q;
    assign bus_err_o      = bus_err_q;

endmodule
